// File: rtl/aead_dec_pkg.sv
// aead_dec_pkg: state encoding and beat-count helpers shared by the
// AEAD decryption lane interface (aead_dec_lane_if) and its lane registers.
package aead_dec_pkg;

  localparam int NONCE_W = 128;
  localparam int TAG_W   = 128;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    WAIT = 2'd2,
    EMIT = 2'd3
  } state_t;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Input beats: longest operand stream over the lane width.
  function automatic int inBeats(input int kw, input int lw, input int yw, input int lane);
    return maxOf(maxOf(kw, NONCE_W), maxOf(lw, yw)) / lane;
  endfunction

  // Output beats: longer of plaintext and tag over the lane width.
  function automatic int outBeats(input int yw, input int lane);
    return maxOf(yw, TAG_W) / lane;
  endfunction

  // Counter width able to hold 0..beats inclusive.
  function automatic int cntWidth(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/aead_dec_lane_if_lane_shift_reg.sv
// lane_shift_reg: N-bit register that shifts W-bit lanes in at the LSB end
// (so the first lane ends up in the MSBs), supports a parallel capture and
// a synchronous clear. Shifting with a zero lane streams the MSB lane out.
module lane_shift_reg #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         loadEn,
  input  logic [N-1:0] loadData,
  input  logic         shiftEn,
  input  logic [W-1:0] laneIn,
  output logic [N-1:0] data
);

  // Clear beats capture, capture beats shift; otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data <= {N{1'b0}};
    end else if (clr) begin
      data <= {N{1'b0}};
    end else if (loadEn) begin
      data <= loadData;
    end else if (shiftEn) begin
      data <= (data << W) | N'(laneIn);
    end else begin
      data <= data;
    end
  end

endmodule

// File: rtl/aead_dec_lane_if.sv
// aead_dec_lane_if: W-bit serial front-end for the AEAD decryption core.
// Deserialises key/nonce/AD/ciphertext, kicks the core, captures plaintext
// and tag, and streams them back out MSB-first.
// Optional feature macro: AEAD_TAG_VERIFY_EN (adds tag_expxSI and the tag
// comparator; a mismatch zeroes the emitted plaintext).
module aead_dec_lane_if
  import aead_dec_pkg::*;
#(
  parameter int k = 128,
  parameter int l = 32,
  parameter int y = 32,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   keyxSI,
  input  logic [W-1:0]   noncexSI,
  input  logic [W-1:0]   associated_dataxSI,
  input  logic [W-1:0]   cipher_textxSI,
`ifdef AEAD_TAG_VERIFY_EN
  input  logic [W-1:0]   tag_expxSI,
`endif
  input  logic           load_validxSI,
  input  logic           startxSI,
  output logic [k-1:0]   core_keyxDO,
  output logic [127:0]   core_noncexDO,
  output logic [l-1:0]   core_adxDO,
  output logic [y-1:0]   core_ctxDO,
  output logic           core_startxSO,
  input  logic [y-1:0]   core_ptxDI,
  input  logic [127:0]   core_tagxDI,
  input  logic           core_readyxSI,
  output logic [W-1:0]   plain_textxSO,
  output logic [W-1:0]   tagxSO,
  output logic           out_validxSO,
  output logic           tag_okxSO,
  output logic           busyxSO,
  output logic           donexSO
);

  localparam int INB    = inBeats(k, l, y, W);
  localparam int OUTB   = outBeats(y, W);
  localparam int CNT_W  = cntWidth(INB);
  localparam int ECNT_W = cntWidth(OUTB);

  localparam logic [CNT_W-1:0]  IN_FULL     = CNT_W'(INB);
  localparam logic [CNT_W-1:0]  KEY_BEATS   = CNT_W'(k / W);
  localparam logic [CNT_W-1:0]  NONCE_BEATS = CNT_W'(NONCE_W / W);
  localparam logic [CNT_W-1:0]  AD_BEATS    = CNT_W'(l / W);
  localparam logic [CNT_W-1:0]  CT_BEATS    = CNT_W'(y / W);
  localparam logic [ECNT_W-1:0] OUT_LAST    = ECNT_W'(OUTB - 1);

  // Lane width must tile every stream exactly.
  if (((k % W) != 0) || ((NONCE_W % W) != 0) || ((l % W) != 0) || ((y % W) != 0)) begin : gLaneCheck
    $error("aead_dec_lane_if: W must divide k, 128, l and y");
  end

  state_t              state_r, stateNext_s;
  logic [CNT_W-1:0]    beatCnt_r;
  logic [ECNT_W-1:0]   emitCnt_r;
  logic                tagOk_r;
  logic                loadBeat_s, coreStart_s, capture_s, emitShift_s, clear_s;
  logic                tagOkCapture_s, outValidNext_s, doneNext_s;
  logic [W-1:0]        ptOutNext_s, tagOutNext_s;
  logic [y-1:0]        ptData_s;
  logic [127:0]        tagData_s;

  lane_shift_reg #(.N(k), .W(W)) uKey (
    .clk(clk), .rst(rst), .clr(clear_s), .loadEn(1'b0), .loadData({k{1'b0}}),
    .shiftEn(loadBeat_s && (beatCnt_r < KEY_BEATS)), .laneIn(keyxSI), .data(core_keyxDO));

  lane_shift_reg #(.N(NONCE_W), .W(W)) uNonce (
    .clk(clk), .rst(rst), .clr(clear_s), .loadEn(1'b0), .loadData({NONCE_W{1'b0}}),
    .shiftEn(loadBeat_s && (beatCnt_r < NONCE_BEATS)), .laneIn(noncexSI), .data(core_noncexDO));

  lane_shift_reg #(.N(l), .W(W)) uAd (
    .clk(clk), .rst(rst), .clr(clear_s), .loadEn(1'b0), .loadData({l{1'b0}}),
    .shiftEn(loadBeat_s && (beatCnt_r < AD_BEATS)), .laneIn(associated_dataxSI), .data(core_adxDO));

  lane_shift_reg #(.N(y), .W(W)) uCt (
    .clk(clk), .rst(rst), .clr(clear_s), .loadEn(1'b0), .loadData({y{1'b0}}),
    .shiftEn(loadBeat_s && (beatCnt_r < CT_BEATS)), .laneIn(cipher_textxSI), .data(core_ctxDO));

  // Results are captured pre-shifted by one lane: lane 0 goes straight to the
  // output register on the capture edge, later lanes come from the MSBs.
  lane_shift_reg #(.N(y), .W(W)) uPt (
    .clk(clk), .rst(rst), .clr(clear_s), .loadEn(capture_s), .loadData(core_ptxDI << W),
    .shiftEn(emitShift_s), .laneIn({W{1'b0}}), .data(ptData_s));

  lane_shift_reg #(.N(TAG_W), .W(W)) uTag (
    .clk(clk), .rst(rst), .clr(clear_s), .loadEn(capture_s), .loadData(core_tagxDI << W),
    .shiftEn(emitShift_s), .laneIn({W{1'b0}}), .data(tagData_s));

`ifdef AEAD_TAG_VERIFY_EN
  logic [127:0] tagExpData_s;

  lane_shift_reg #(.N(TAG_W), .W(W)) uTagExp (
    .clk(clk), .rst(rst), .clr(clear_s), .loadEn(1'b0), .loadData({TAG_W{1'b0}}),
    .shiftEn(loadBeat_s && (beatCnt_r < CNT_W'(TAG_W / W))), .laneIn(tag_expxSI), .data(tagExpData_s));

  assign tagOkCapture_s = (core_tagxDI == tagExpData_s);
`else
  assign tagOkCapture_s = 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= LOAD;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    stateNext_s = state_r;
    loadBeat_s  = 1'b0;
    coreStart_s = 1'b0;
    capture_s   = 1'b0;
    emitShift_s = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      LOAD: begin
        if (load_validxSI && (beatCnt_r != IN_FULL)) begin
          loadBeat_s = 1'b1;
        end else begin
          loadBeat_s = 1'b0;
        end
        if (startxSI && (beatCnt_r == IN_FULL)) begin
          stateNext_s = KICK;
          coreStart_s = 1'b1;
        end else begin
          stateNext_s = LOAD;
          coreStart_s = 1'b0;
        end
      end
      KICK: begin
        stateNext_s = WAIT;
      end
      WAIT: begin
        if (core_readyxSI) begin
          stateNext_s = EMIT;
          capture_s   = 1'b1;
        end else begin
          stateNext_s = WAIT;
          capture_s   = 1'b0;
        end
      end
      EMIT: begin
        if (emitCnt_r == OUT_LAST) begin
          stateNext_s = LOAD;
          clear_s     = 1'b1;
        end else begin
          stateNext_s = EMIT;
          emitShift_s = 1'b1;
        end
      end
      default: begin
        stateNext_s = LOAD;
        clear_s     = 1'b1;
      end
    endcase
  end

  // Next values of the registered result lanes and their flags.
  always_comb begin
    outValidNext_s = capture_s | emitShift_s;
    doneNext_s     = 1'b0;
    ptOutNext_s    = {W{1'b0}};
    tagOutNext_s   = {W{1'b0}};
    if (capture_s) begin
      doneNext_s   = (OUT_LAST == {ECNT_W{1'b0}});
      ptOutNext_s  = tagOkCapture_s ? core_ptxDI[y-1 -: W] : {W{1'b0}};
      tagOutNext_s = core_tagxDI[127 -: W];
    end else if (emitShift_s) begin
      doneNext_s   = ((emitCnt_r + ECNT_W'(1)) == OUT_LAST);
      ptOutNext_s  = tagOk_r ? ptData_s[y-1 -: W] : {W{1'b0}};
      tagOutNext_s = tagData_s[127 -: W];
    end else begin
      doneNext_s   = 1'b0;
      ptOutNext_s  = {W{1'b0}};
      tagOutNext_s = {W{1'b0}};
    end
  end

  // Beat counters, tag status and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beatCnt_r     <= {CNT_W{1'b0}};
      emitCnt_r     <= {ECNT_W{1'b0}};
      tagOk_r       <= 1'b0;
      core_startxSO <= 1'b0;
      out_validxSO  <= 1'b0;
      donexSO       <= 1'b0;
      busyxSO       <= 1'b0;
      plain_textxSO <= {W{1'b0}};
      tagxSO        <= {W{1'b0}};
    end else begin
      if (clear_s) begin
        beatCnt_r <= {CNT_W{1'b0}};
      end else if (loadBeat_s) begin
        beatCnt_r <= beatCnt_r + CNT_W'(1);
      end else begin
        beatCnt_r <= beatCnt_r;
      end
      if (emitShift_s) begin
        emitCnt_r <= emitCnt_r + ECNT_W'(1);
      end else if (capture_s || clear_s) begin
        emitCnt_r <= {ECNT_W{1'b0}};
      end else begin
        emitCnt_r <= emitCnt_r;
      end
      // Tag status is held through LOAD until fresh operands arrive.
      if (capture_s) begin
        tagOk_r <= tagOkCapture_s;
      end else if (loadBeat_s) begin
        tagOk_r <= 1'b0;
      end else begin
        tagOk_r <= tagOk_r;
      end
      core_startxSO <= coreStart_s;
      out_validxSO  <= outValidNext_s;
      donexSO       <= doneNext_s;
      busyxSO       <= (stateNext_s != LOAD);
      plain_textxSO <= ptOutNext_s;
      tagxSO        <= tagOutNext_s;
    end
  end

  assign tag_okxSO = tagOk_r;

endmodule
